// File: rtl/line_mem_pkg.sv
// Shared types and helpers for the line memory responder.
package line_mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;

  localparam int unsigned WORD_W = 32;

  // Words per line for a given log2 line length.
  function automatic int unsigned line_size(input int unsigned line_addr_len);
    return 32'd1 << line_addr_len;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Whole-line storage: one synchronous write port and one registered read port.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          wr_en,
  input  logic                                          rd_en,
  input  logic [ADDR_LEN-1:0]                           addr,
  input  logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]    wr_data,
  output logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]    rd_data
);

  localparam int unsigned LINE_W = WORD_W * line_size(LINE_ADDR_LEN);
  localparam int unsigned DEPTH  = 32'd1 << ADDR_LEN;

  logic [LINE_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency whole-line memory responder for cache refill/writeback.
// Optional MEM_STATS_EN adds saturating read/write completion counters.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9,
  parameter int unsigned LATENCY       = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [ADDR_LEN-1:0]                           addr,
  input  logic                                          rd_req,
  input  logic                                          wr_req,
  input  logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]    wr_line,
  output logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]    rd_line,
  output logic                                          gnt
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]                                   rd_cnt,
  output logic [31:0]                                   wr_cnt
`endif
);

  localparam int unsigned LINE_W = WORD_W * line_size(LINE_ADDR_LEN);
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e              state;
  op_e                 op_q;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_LEN-1:0] addr_q;
  logic [LINE_W-1:0]   line_q;

  logic commit_c;
  logic mem_wr_c;
  logic mem_rd_c;

  assign commit_c = (state == BUSY) && (cnt == '0);
  assign mem_wr_c = commit_c && (op_q == OP_WR);
  assign mem_rd_c = commit_c && (op_q == OP_RD);

  // Request latch, latency counter and completion pulse; writes win over reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_RD;
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
      gnt    <= 1'b0;
    end else begin
      gnt <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req || rd_req) begin
            op_q   <= wr_req ? OP_WR : OP_RD;
            addr_q <= addr;
            line_q <= wr_line;
            cnt    <= CNT_W'(LATENCY - 1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
            gnt   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  line_mem_array #(
    .LINE_ADDR_LEN (LINE_ADDR_LEN),
    .ADDR_LEN      (ADDR_LEN)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (mem_wr_c),
    .rd_en   (mem_rd_c),
    .addr    (addr_q),
    .wr_data (line_q),
    .rd_data (rd_line)
  );

`ifdef MEM_STATS_EN
  // Completion counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (mem_rd_c && (rd_cnt != '1)) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (mem_wr_c && (wr_cnt != '1)) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder (LATENCY=8 and LATENCY=1 instances).
module tb_line_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [8:0]   addr, addr1;
  logic         rd_req, wr_req, rd_req1, wr_req1;
  logic [255:0] wr_line, wr_line1, rd_line, rd_line1;
  logic         gnt, gnt1;
`ifdef MEM_STATS_EN
  logic [31:0]  rd_cnt, wr_cnt, rd_cnt1, wr_cnt1;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int consec0     = 0;
  int consec1     = 0;
  logic gnt_prev  = 1'b0;
  logic gnt1_prev = 1'b0;

  always #5 clk = ~clk;

  line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_line(wr_line), .rd_line(rd_line), .gnt(gnt)
`ifdef MEM_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr1), .rd_req(rd_req1), .wr_req(wr_req1),
    .wr_line(wr_line1), .rd_line(rd_line1), .gnt(gnt1)
`ifdef MEM_STATS_EN
    , .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
`endif
  );

  // Back-to-back gnt detector for both instances.
  always @(negedge clk) begin
    if (gnt && gnt_prev) consec0++;
    if (gnt1 && gnt1_prev) consec1++;
    gnt_prev  = gnt;
    gnt1_prev = gnt1;
  end

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + step * 32'(i);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Issue one request from an IDLE cycle, drop it in the gnt cycle; lat counts edges to gnt.
  task automatic run_op(input logic w, input logic r, input logic [8:0] a,
                        input logic [255:0] line, output int lat);
    addr = a; wr_line = line; wr_req = w; rd_req = r; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!gnt && lat < 40);
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  typedef struct {
    logic         is_wr;
    logic [8:0]   a;
    logic [255:0] line;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl[10];
  int   lat, n, g;
  logic [255:0] la0, l300, l2000, lff, lc0, l11, l4400;

  initial begin
    la0   = mk_line(32'hA0, 32'd1);
    l300  = mk_line(32'h300, 32'd1);
    l2000 = mk_line(32'h2000, 32'd1);
    lff   = mk_line(32'hFFFF_0000, 32'd1);
    lc0   = mk_line(32'hC0, 32'd1);
    l11   = mk_line(32'h11, 32'd0);
    l4400 = mk_line(32'h4400, 32'd1);

    // exp is rd_line after the gnt; writes leave the last read value in place.
    tbl[0] = '{1'b1, 9'h005, la0,   '0};
    tbl[1] = '{1'b0, 9'h005, '0,    la0};
    tbl[2] = '{1'b1, 9'h003, l300,  la0};
    tbl[3] = '{1'b1, 9'h020, l2000, la0};
    tbl[4] = '{1'b0, 9'h003, '0,    l300};
    tbl[5] = '{1'b1, 9'h1FF, lff,   l300};
    tbl[6] = '{1'b0, 9'h1FF, '0,    lff};
    tbl[7] = '{1'b1, 9'h000, lc0,   lff};
    tbl[8] = '{1'b0, 9'h000, '0,    lc0};
    tbl[9] = '{1'b0, 9'h005, '0,    la0};

    rst_n = 1'b0; addr = '0; rd_req = 0; wr_req = 0; wr_line = '0;
    addr1 = '0; rd_req1 = 0; wr_req1 = 0; wr_line1 = '0;
    #3;
    chk("reset_gnt", 256'(gnt), 256'(0));
    chk("reset_rd_line", rd_line, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].is_wr, !tbl[i].is_wr, tbl[i].a, tbl[i].line, lat);
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(9));
      chk($sformatf("vec%0d_rd_line", i), rd_line, tbl[i].exp);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_gnt_single", i), 256'(gnt), 256'(0));
      chk($sformatf("vec%0d_rd_line_hold", i), rd_line, tbl[i].exp);
    end

    // Asynchronous reset in the middle of a gnt cycle.
    run_op(1'b0, 1'b1, 9'h003, '0, lat);
    chk("pre_reset_rd_line", rd_line, l300);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_gnt", 256'(gnt), 256'(0));
    chk("async_reset_rd_line", rd_line, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous read and write: write first, read accepted in the next IDLE.
    addr = 9'h010; wr_line = l11; wr_req = 1'b1; rd_req = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!gnt && lat < 40);
    wr_req = 1'b0;
    chk("both_wr_latency", 256'(lat), 256'(9));
    chk("both_wr_rd_line", rd_line, '0);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!gnt && lat < 40);
    rd_req = 1'b0;
    chk("both_rd_latency", 256'(lat), 256'(10));
    chk("both_rd_line", rd_line, l11);
    @(posedge clk); #1;

    // One-cycle read pulse still completes with a single gnt.
    addr = 9'h003; rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0; addr = 9'h1FF; lat = 1;
    while (!gnt && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("pulse_latency", 256'(lat), 256'(9));
    chk("pulse_rd_line", rd_line, l300);
    g = 0;
    repeat (12) begin @(posedge clk); #1; if (gnt) g++; end
    chk("pulse_no_extra_gnt", 256'(g), 256'(0));

    // Reset while a write is in flight with cnt==3 discards the write.
    addr = 9'h020; wr_line = mk_line(32'hDEAD_0000, 32'd1); wr_req = 1'b1;
    @(posedge clk); #1;
    addr = 9'h000; wr_line = '0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0; wr_req = 1'b0;
    g = 0;
    repeat (3) begin @(posedge clk); #1; if (gnt) g++; end
    chk("reset_abort_no_gnt", 256'(g), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 9'h020, '0, lat);
    chk("abort_rd_latency", 256'(lat), 256'(9));
    chk("abort_rd_line", rd_line, l2000);
    @(posedge clk); #1;
`ifdef MEM_STATS_EN
    chk("stats_rd_cnt", 256'(rd_cnt), 256'(1));
    chk("stats_wr_cnt", 256'(wr_cnt), 256'(0));
`endif

    // LATENCY=1 instance: three back-to-back writes, then two reads.
    addr1 = 9'h044; wr_line1 = l4400; wr_req1 = 1'b1; n = 0; g = 0;
    while (g < 3 && n < 40) begin
      @(posedge clk); #1; n++;
      if (gnt1) begin g++; if (g == 3) wr_req1 = 1'b0; end
    end
    chk("l1_wr_gnts", 256'(g), 256'(3));
    chk("l1_wr_cycles", 256'(n), 256'(8));
    @(posedge clk); #1;
    rd_req1 = 1'b1; n = 0; g = 0;
    while (g < 2 && n < 40) begin
      @(posedge clk); #1; n++;
      if (gnt1) begin
        g++;
        chk($sformatf("l1_rd%0d_line", g), rd_line1, l4400);
        if (g == 2) rd_req1 = 1'b0;
      end
    end
    chk("l1_rd_gnts", 256'(g), 256'(2));
    chk("l1_rd_cycles", 256'(n), 256'(5));
    @(posedge clk); #1;
`ifdef MEM_STATS_EN
    chk("l1_wr_cnt", 256'(wr_cnt1), 256'(3));
    chk("l1_rd_cnt", 256'(rd_cnt1), 256'(2));
`endif
    chk("l8_no_consec_gnt", 256'(consec0), 256'(0));
    chk("l1_no_consec_gnt", 256'(consec1), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
